// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared state encoding and constants for the memory port arbiter
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_DM_BUSY  = 2'd2,
        ST_IF_DRAIN = 2'd3
    } arb_state_t;

    // Read data handed back to the owner when its access is aborted by timeout
    localparam logic [63:0] ERR_RDATA = 64'h0;

    // Instruction fetches always read the whole word
    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - busy-cycle counter that flags an unanswered memory request
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Expiry fires in the cycle whose increment would make the count reach TIMEOUT_CYC
    assign expired = enable & (r_cnt == LAST);

    // Count busy cycles; a new grant restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and data ports onto one memory port
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_be,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              bus_err
);

    arb_state_t        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_mem_be;
    logic              r_if_ready;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_dm_ready;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_bus_err;

    logic w_dm_grant;
    logic w_if_grant;
    logic w_cnt_en;
    logic w_expired;

    // Data wins in IDLE; a port whose ready is pulsing this cycle is masked so its held request is not re-granted
    assign w_dm_grant = (r_state == ST_IDLE) & dm_req & ~r_dm_ready;
    assign w_if_grant = (r_state == ST_IDLE) & if_req & ~r_if_ready & ~if_flush & ~w_dm_grant;
    assign w_cnt_en   = r_mem_req & ~mem_ack;

    mem_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_dm_grant | w_if_grant),
        .enable  (w_cnt_en),
        .expired (w_expired)
    );

    // Arbitration FSM with registered memory-side and completion outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_ready  <= 1'b0;
            r_dm_rdata  <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_if_rdata <= '0;
            r_dm_ready <= 1'b0;
            r_dm_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_dm_grant) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        r_mem_be    <= dm_be;
                        r_state     <= ST_DM_BUSY;
                    end else if (w_if_grant) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_mem_be    <= FETCH_BE;
                        r_state     <= ST_IF_BUSY;
                    end
                end
                ST_IF_BUSY: begin
                    // A flush arriving with the ack or the timeout still cancels the fetch result
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (!if_flush) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= mem_rdata;
                        end
                    end else if (w_expired) begin
                        r_mem_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= ST_IDLE;
                        if (!if_flush) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= DATA_W'(ERR_RDATA);
                        end
                    end else if (if_flush) begin
                        r_state <= ST_IF_DRAIN;
                    end
                end
                ST_DM_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_state    <= ST_IDLE;
                        r_dm_ready <= 1'b1;
                        r_dm_rdata <= r_mem_we ? '0 : mem_rdata;
                    end else if (w_expired) begin
                        r_mem_req  <= 1'b0;
                        r_bus_err  <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_dm_ready <= 1'b1;
                        r_dm_rdata <= DATA_W'(ERR_RDATA);
                    end
                end
                ST_IF_DRAIN: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_expired) begin
                        r_mem_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign dm_ready  = r_dm_ready;
    assign dm_rdata  = r_dm_rdata;
    assign bus_err   = r_bus_err;
    assign stall     = (if_req & ~r_if_ready) | (dm_req & ~r_dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        bus_err;

    int n_tests;
    int n_fail;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs for the new cycle are driven here
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        step();
        #1;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b exp 0", mem_req); end
        n_tests++; if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got if=%0b dm=%0b exp 0/0", if_ready, dm_ready); end
        n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %0b exp 0", bus_err); end
        n_tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_fields: got addr=%h wdata=%h be=%h we=%0b exp zeros", mem_addr, mem_wdata, mem_be, mem_we); end
        n_tests++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0 || stall !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_stall: got if=%h dm=%h stall=%0b exp 0", if_rdata, dm_rdata, stall); end
        rst = 1'b1;
    endtask

    // Starts in the release cycle, so this also covers the first grant after reset
    task automatic test_single_fetch();
        int pulses;
        pulses = 0;
        if_req = 1'b1; if_addr = 32'h0000_0004;
        #1;
        n_tests++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_c0: got stall=%0b mem_req=%0b exp 1/0", stall, mem_req); end
        step();
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || mem_we !== 1'b0 || mem_be !== 4'hF) begin n_fail++; $display("FAIL fetch_issue: got req=%0b addr=%h we=%0b be=%h exp 1/00000004/0/f", mem_req, mem_addr, mem_we, mem_be); end
        if (if_ready) pulses++;
        mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        n_tests++; if (if_ready !== 1'b1 || if_rdata !== 32'h2008_0005) begin n_fail++; $display("FAIL fetch_ready: got ready=%0b rdata=%h exp 1/20080005", if_ready, if_rdata); end
        n_tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL fetch_done: got mem_req=%0b stall=%0b exp 0/0", mem_req, stall); end
        if (if_ready) pulses++;
        step();
        if_req = 1'b0;
        #1;
        if (if_ready) pulses++;
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL fetch_pulse_count: got %0d exp 1", pulses); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_no_regrant: got mem_req=%0b exp 0", mem_req); end
        step();
    endtask

    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 32'h0000_0040;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_1000; dm_be = 4'hF; dm_wdata = 32'h0;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sim_stall_c0: got %0b exp 1", stall); end
        step();
        #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000 || mem_we !== 1'b0) begin n_fail++; $display("FAIL sim_dm_first: got req=%0b addr=%h we=%0b exp 1/00001000/0", mem_req, mem_addr, mem_we); end
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sim_stall_c1: got %0b exp 1", stall); end
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        n_tests++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h1111_2222 || if_ready !== 1'b0) begin n_fail++; $display("FAIL sim_dm_ready: got dm_ready=%0b rdata=%h if_ready=%0b exp 1/11112222/0", dm_ready, dm_rdata, if_ready); end
        n_tests++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL sim_c2: got stall=%0b mem_req=%0b exp 1/0", stall, mem_req); end
        step();
        dm_req = 1'b0;
        #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin n_fail++; $display("FAIL sim_if_second: got req=%0b addr=%h we=%0b exp 1/00000040/0", mem_req, mem_addr, mem_we); end
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sim_stall_c3: got %0b exp 1", stall); end
        mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        n_tests++; if (if_ready !== 1'b1 || if_rdata !== 32'h3333_4444 || stall !== 1'b0) begin n_fail++; $display("FAIL sim_if_ready: got ready=%0b rdata=%h stall=%0b exp 1/33334444/0", if_ready, if_rdata, stall); end
        step();
        if_req = 1'b0;
        #1;
        n_tests++; if (mem_req !== 1'b0 || dm_ready !== 1'b0) begin n_fail++; $display("FAIL sim_idle: got mem_req=%0b dm_ready=%0b exp 0/0", mem_req, dm_ready); end
        step();
    endtask

    task automatic test_flush();
        int if_pulses;
        if_pulses = 0;
        if_req = 1'b1; if_addr = 32'h0000_0080;
        step();
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin n_fail++; $display("FAIL flush_issue: got req=%0b addr=%h exp 1/00000080", mem_req, mem_addr); end
        if_req = 1'b0; if_flush = 1'b1;
        step();
        if_flush = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_1234; dm_be = 4'h3;
        #1;
        if (if_ready) if_pulses++;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin n_fail++; $display("FAIL flush_drain_hold: got req=%0b addr=%h exp 1/00000080", mem_req, mem_addr); end
        step();
        if (if_ready) if_pulses++;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin n_fail++; $display("FAIL flush_no_dm_in_drain: got req=%0b addr=%h exp 1/00000080", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        if (if_ready) if_pulses++;
        n_tests++; if (mem_req !== 1'b0 || dm_ready !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got mem_req=%0b dm_ready=%0b exp 0/0", mem_req, dm_ready); end
        step();
        if (if_ready) if_pulses++;
        n_tests++; if (if_pulses != 0) begin n_fail++; $display("FAIL flush_no_if_ready: got %0d pulses exp 0", if_pulses); end
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h1234 || mem_be !== 4'h3) begin n_fail++; $display("FAIL flush_dm_after: got req=%0b addr=%h be=%h exp 1/00001234/3", mem_req, mem_addr, mem_be); end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0005;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        n_tests++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h5) begin n_fail++; $display("FAIL flush_dm_ready: got ready=%0b rdata=%h exp 1/00000005", dm_ready, dm_rdata); end
        step();
        dm_req = 1'b0;
        step();
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_2000; dm_wdata = 32'hCAFE_F00D; dm_be = 4'hF;
        step();
        n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'hCAFE_F00D || mem_be !== 4'hF) begin n_fail++; $display("FAIL store_issue: got req=%0b we=%0b addr=%h wdata=%h be=%h exp 1/1/00002000/cafef00d/f", mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
        step();
        n_tests++; if (mem_req !== 1'b1 || mem_wdata !== 32'hCAFE_F00D || dm_ready !== 1'b0) begin n_fail++; $display("FAIL store_hold: got req=%0b wdata=%h dm_ready=%0b exp 1/cafef00d/0", mem_req, mem_wdata, dm_ready); end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        n_tests++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL store_ready: got ready=%0b rdata=%h mem_req=%0b exp 1/00000000/0", dm_ready, dm_rdata, mem_req); end
        step();
        dm_req = 1'b0; dm_we = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_3000; dm_be = 4'hF;
        mem_rdata = 32'hFFFF_FFFF;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_tests++; if (mem_req !== 1'b1 || bus_err !== 1'b0 || dm_ready !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_c%0d: got req=%0b err=%0b ready=%0b exp 1/0/0", c, mem_req, bus_err, dm_ready); end
        end
        step();
        n_tests++; if (bus_err !== 1'b1 || dm_ready !== 1'b1 || dm_rdata !== 32'h0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_abort: got err=%0b ready=%0b rdata=%h req=%0b exp 1/1/00000000/0", bus_err, dm_ready, dm_rdata, mem_req); end
        step();
        dm_req = 1'b0;
        mem_rdata = 32'h0;
        for (int c = 0; c < 10; c++) step();
        n_tests++; if (bus_err !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_sticky: got err=%0b req=%0b exp 1/0", bus_err, mem_req); end
    endtask

    task automatic test_reset_mid_op();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_4000; dm_be = 4'hF;
        step();
        #1;
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got req=%0b exp 1", mem_req); end
        rst = 1'b0;
        dm_req = 1'b0;
        #1;
        n_tests++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || bus_err !== 1'b0 || dm_ready !== 1'b0 || if_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got req=%0b addr=%h be=%h err=%0b dm_ready=%0b if_ready=%0b exp all 0", mem_req, mem_addr, mem_be, bus_err, dm_ready, if_ready); end
        step();
        step();
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        if_req = 1'b1; if_addr = 32'h0000_0008;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || if_ready !== 1'b0 || dm_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_ack: got req=%0b addr=%h if_ready=%0b dm_ready=%0b exp 1/00000008/0/0", mem_req, mem_addr, if_ready, dm_ready); end
        mem_ack = 1'b1; mem_rdata = 32'h0A0B_0C0D;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        n_tests++; if (if_ready !== 1'b1 || if_rdata !== 32'h0A0B_0C0D || bus_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_new_fetch: got ready=%0b rdata=%h err=%0b exp 1/0a0b0c0d/0", if_ready, if_rdata, bus_err); end
        step();
        if_req = 1'b0;
        step();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        if_flush  = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        dm_be     = 4'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;

        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_flush();
        test_store();
        test_timeout();
        test_reset_mid_op();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
